// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the SRAM port arbiter.
// Requester indices match the top-level wiring order.
package sram_arb_pkg;

    localparam int NUM_REQ_DEFAULT = 4;

    localparam int REQ_VGA  = 0;
    localparam int REQ_UART = 1;
    localparam int REQ_M1   = 2;
    localparam int REQ_M2   = 3;

    localparam logic [17:0] PROT_LIMIT_DEFAULT = 18'd146944;

    typedef logic [17:0] sram_addr_t;
    typedef logic [15:0] sram_data_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker over requesters 1..NUM_REQ-1.
// Scans from ptr upward, wrapping back to 1; index 0 is ignored.
module rr_pick
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEFAULT
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         pick,
    output logic [$clog2(NUM_REQ)-1:0] ptr_next,
    output logic                       any
);

    localparam int PW = $clog2(NUM_REQ);

    logic [PW:0]   idx;
    logic [PW-1:0] sel;

    always_comb begin
        pick     = '0;
        ptr_next = ptr;
        any      = 1'b0;
        idx      = '0;
        sel      = '0;
        for (int k = 0; k < NUM_REQ - 1; k++) begin
            idx = {1'b0, ptr} + (PW+1)'(k);
            if (idx >= (PW+1)'(NUM_REQ)) begin
                idx = idx - (PW+1)'(NUM_REQ - 1);
            end
            sel = idx[PW-1:0];
            if (!any && req[sel]) begin
                any       = 1'b1;
                pick[sel] = 1'b1;
                ptr_next  = (sel == PW'(NUM_REQ - 1)) ? PW'(1) : sel + PW'(1);
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM port among NUM_REQ requesters with read-data return tags.
// Optional SRAM_ARB_PERF_EN adds per-requester grant/wait counters.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int                 NUM_REQ      = NUM_REQ_DEFAULT,
    parameter int                 READ_LATENCY = 2,
    parameter sram_addr_t         PROT_LIMIT   = PROT_LIMIT_DEFAULT,
    parameter logic [NUM_REQ-1:0] PROT_MASK    = 4'b1100
) (
    input  logic                     Clock_50,
    input  logic                     Resetn,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       req_we_n,
    input  sram_addr_t [NUM_REQ-1:0] req_addr,
    input  sram_data_t [NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       rvalid,
    output sram_data_t               rdata,
    output sram_addr_t               SRAM_address,
    output sram_data_t               SRAM_write_data,
    output logic                     SRAM_we_n,
    input  sram_data_t               SRAM_read_data,
    output logic                     prot_violation
`ifdef SRAM_ARB_PERF_EN
    ,
    output logic [NUM_REQ-1:0][23:0] perf_gnt_cnt,
    output logic [NUM_REQ-1:0][23:0] perf_wait_cnt
`endif
);

    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0]      ptr;
    logic [PW-1:0]      ptr_next;
    logic [NUM_REQ-1:0] rr_gnt;
    logic [NUM_REQ-1:0] gnt_raw;
    logic               rr_any;

    sram_addr_t win_addr;
    sram_data_t win_wdata;
    logic       win_we_n;
    logic       win_mask;
    logic       blocked;

    logic [NUM_REQ-1:0] tags [READ_LATENCY+1];

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr (
        .req      (req),
        .ptr      (ptr),
        .pick     (rr_gnt),
        .ptr_next (ptr_next),
        .any      (rr_any)
    );

    assign gnt_raw = req[0] ? NUM_REQ'(1) : rr_gnt;
    assign gnt     = gnt_raw & {NUM_REQ{Resetn}};

    always_comb begin
        win_addr  = '0;
        win_wdata = '0;
        win_we_n  = 1'b1;
        win_mask  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                win_addr  = req_addr[i];
                win_wdata = req_wdata[i];
                win_we_n  = req_we_n[i];
                win_mask  = PROT_MASK[i];
            end
        end
    end

    // Blocked writes still take the slot but go out as a no-op read cycle.
    assign blocked = !win_we_n && win_mask && (win_addr < PROT_LIMIT);

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            ptr             <= PW'(1);
            SRAM_address    <= '0;
            SRAM_write_data <= '0;
            SRAM_we_n       <= 1'b1;
            prot_violation  <= 1'b0;
            for (int k = 0; k <= READ_LATENCY; k++) begin
                tags[k] <= '0;
            end
        end else begin
            SRAM_we_n <= 1'b1;
            if (|gnt) begin
                SRAM_address    <= win_addr;
                SRAM_write_data <= win_wdata;
                SRAM_we_n       <= win_we_n | blocked;
            end
            if (blocked) begin
                prot_violation <= 1'b1;
            end
            if (!req[0] && rr_any) begin
                ptr <= ptr_next;
            end
            tags[0] <= win_we_n ? gnt : '0;
            for (int k = 1; k <= READ_LATENCY; k++) begin
                tags[k] <= tags[k-1];
            end
        end
    end

    assign rvalid = tags[READ_LATENCY];
    assign rdata  = SRAM_read_data;

`ifdef SRAM_ARB_PERF_EN
    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            perf_gnt_cnt  <= '0;
            perf_wait_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt[i] && perf_gnt_cnt[i] != '1) begin
                    perf_gnt_cnt[i] <= perf_gnt_cnt[i] + 24'd1;
                end
                if (req[i] && !gnt[i] && perf_wait_cnt[i] != '1) begin
                    perf_wait_cnt[i] <= perf_wait_cnt[i] + 24'd1;
                end
            end
        end
    end
`endif

endmodule
